// File: rtl/dbg_guv_pkg.sv
// Shared constants and types for the dbg_guv stream debug governor:
// command field layout, shadow register indices and flag bit positions.
package dbg_guv_pkg;

   localparam int REG_LSB  = 0;
   localparam int REG_W    = 4;
   localparam int ADDR_LSB = REG_LSB + REG_W;

   localparam logic [REG_W-1:0] REG_DROP_CNT = 4'd0;
   localparam logic [REG_W-1:0] REG_LOG_CNT  = 4'd1;
   localparam logic [REG_W-1:0] REG_FLAGS    = 4'd2;
   localparam logic [REG_W-1:0] REG_LATCH    = 4'd15;

   localparam int FLAG_PAUSE = 0;
   localparam int FLAG_LOG   = 1;
   localparam int FLAG_DROP  = 2;
   localparam int FLAG_W     = 3;

   typedef struct packed {
      logic pause;
      logic drop;
      logic log;
   } mode_t;

endpackage

// File: rtl/dbg_guv_cmd.sv
// Command decode, shadow/active register bank and cmd daisy-chain forwarding
// for one dbg_guv core.
module dbg_guv_cmd
   import dbg_guv_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int CNT_SIZE    = 16,
   parameter int ADDR_WIDTH  = 12,
   parameter int ADDR        = 0,
   parameter int STICKY_MODE = 1,
   parameter int PIPE_STAGE  = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] cmd_tdata_i,
   input  logic                  cmd_tvalid_i,
   input  logic                  flit_i,
   output logic [DATA_WIDTH-1:0] cmd_tdata_o,
   output logic                  cmd_tvalid_o,
   output mode_t                 mode_o
);

   localparam int PAY_LSB = ADDR_LSB + ADDR_WIDTH;

   logic [REG_W-1:0]      reg_sel;
   logic [ADDR_WIDTH-1:0] core_addr;
   logic [CNT_SIZE-1:0]   pay_cnt;
   logic [FLAG_W-1:0]     pay_flags;
   logic                  hit, latch, fwd_vld;

   logic [CNT_SIZE-1:0] sh_drop_q, sh_drop_d, sh_log_q, sh_log_d;
   logic [CNT_SIZE-1:0] drop_q, drop_d, log_q, log_d;
   logic [FLAG_W-1:0]   sh_flags_q, sh_flags_d, flags_q, flags_d;

   assign reg_sel   = cmd_tdata_i[REG_LSB +: REG_W];
   assign core_addr = cmd_tdata_i[ADDR_LSB +: ADDR_WIDTH];
   assign pay_cnt   = cmd_tdata_i[PAY_LSB +: CNT_SIZE];
   assign pay_flags = cmd_tdata_i[PAY_LSB +: FLAG_W];
   assign hit       = cmd_tvalid_i && (core_addr == ADDR_WIDTH'(ADDR));
   assign latch     = hit && (reg_sel == REG_LATCH);
   assign fwd_vld   = cmd_tvalid_i && !hit;

   always_comb begin
      sh_drop_d  = sh_drop_q;
      sh_log_d   = sh_log_q;
      sh_flags_d = sh_flags_q;
      drop_d     = drop_q;
      log_d      = log_q;
      flags_d    = flags_q;
      if (hit) begin
         case (reg_sel)
            REG_DROP_CNT: sh_drop_d  = pay_cnt;
            REG_LOG_CNT:  sh_log_d   = pay_cnt;
            REG_FLAGS:    sh_flags_d = pay_flags;
            REG_LATCH: if (STICKY_MODE == 0) begin
               sh_drop_d  = '0;
               sh_log_d   = '0;
               sh_flags_d = '0;
            end
            default: ;
         endcase
      end
      // A latch overrides any flit decrement happening in the same cycle.
      if (latch) begin
         drop_d  = sh_drop_q;
         log_d   = sh_log_q;
         flags_d = sh_flags_q;
      end else begin
         if (flit_i && drop_q != '0) drop_d = drop_q - CNT_SIZE'(1);
         if (flit_i && log_q != '0)  log_d  = log_q - CNT_SIZE'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_drop_q  <= '0;
         sh_log_q   <= '0;
         sh_flags_q <= '0;
         drop_q     <= '0;
         log_q      <= '0;
         flags_q    <= '0;
      end else begin
         sh_drop_q  <= sh_drop_d;
         sh_log_q   <= sh_log_d;
         sh_flags_q <= sh_flags_d;
         drop_q     <= drop_d;
         log_q      <= log_d;
         flags_q    <= flags_d;
      end
   end

   assign mode_o.pause = flags_q[FLAG_PAUSE];
   assign mode_o.drop  = flags_q[FLAG_DROP] | (drop_q != '0);
   assign mode_o.log   = flags_q[FLAG_LOG]  | (log_q != '0);

   generate
      if (PIPE_STAGE != 0) begin : g_pipe
         logic [DATA_WIDTH-1:0] fwd_data_q;
         logic                  fwd_vld_q;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               fwd_data_q <= '0;
               fwd_vld_q  <= 1'b0;
            end else begin
               fwd_data_q <= cmd_tdata_i;
               fwd_vld_q  <= fwd_vld;
            end
         end
         assign cmd_tdata_o  = fwd_data_q;
         assign cmd_tvalid_o = fwd_vld_q;
      end else begin : g_comb
         assign cmd_tdata_o  = cmd_tdata_i;
         assign cmd_tvalid_o = fwd_vld;
      end
   endgenerate

endmodule

// File: rtl/dbg_guv.sv
// Stream debug governor: pauses, drops and/or logs AXI-stream flits under
// control of a daisy-chained command stream.
module dbg_guv
   import dbg_guv_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int DEST_WIDTH  = 16,
   parameter int ID_WIDTH    = 16,
   parameter int CNT_SIZE    = 16,
   parameter int ADDR_WIDTH  = 12,
   parameter int ADDR        = 0,
   parameter int RESET_TYPE  = 0,
   parameter int STICKY_MODE = 1,
   parameter int PIPE_STAGE  = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [DATA_WIDTH-1:0]              cmd_in_TDATA,
   input  logic                               cmd_in_TVALID,
   output logic [DATA_WIDTH-1:0]              cmd_out_TDATA,
   output logic                               cmd_out_TVALID,
   input  logic [DATA_WIDTH-1:0]              in_TDATA,
   input  logic                               in_TVALID,
   input  logic [DATA_WIDTH/8-1:0]            in_TKEEP,
   input  logic [DEST_WIDTH-1:0]              in_TDEST,
   input  logic [ID_WIDTH-1:0]                in_TID,
   input  logic                               in_TLAST,
   output logic                               in_TREADY,
   output logic [DATA_WIDTH-1:0]              out_TDATA,
   output logic                               out_TVALID,
   output logic [DATA_WIDTH/8-1:0]            out_TKEEP,
   output logic [DEST_WIDTH-1:0]              out_TDEST,
   output logic [ID_WIDTH-1:0]                out_TID,
   output logic                               out_TLAST,
   input  logic                               out_TREADY,
   output logic [DATA_WIDTH+DATA_WIDTH/8-1:0] log_catted_TDATA,
   output logic                               log_catted_TVALID,
   output logic                               log_catted_TLAST,
   input  logic                               log_catted_TREADY
);

   mode_t mode;
   logic  flit;

   dbg_guv_cmd #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_SIZE   (CNT_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ADDR       (ADDR),
      .STICKY_MODE(STICKY_MODE),
      .PIPE_STAGE (PIPE_STAGE)
   ) u_cmd (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_tdata_i (cmd_in_TDATA),
      .cmd_tvalid_i(cmd_in_TVALID),
      .flit_i      (flit),
      .cmd_tdata_o (cmd_out_TDATA),
      .cmd_tvalid_o(cmd_out_TVALID),
      .mode_o      (mode)
   );

   // Ready never depends on any valid, so no combinational loop can form.
   assign in_TREADY  = !mode.pause && (mode.drop || out_TREADY) && (!mode.log || log_catted_TREADY);
   assign out_TVALID = in_TVALID && !mode.pause && !mode.drop && (!mode.log || log_catted_TREADY);
   assign log_catted_TVALID = in_TVALID && mode.log && !mode.pause && (mode.drop || out_TREADY);
   assign flit = in_TVALID && in_TREADY;

   assign out_TDATA = in_TDATA;
   assign out_TKEEP = in_TKEEP;
   assign out_TDEST = in_TDEST;
   assign out_TID   = in_TID;
   assign out_TLAST = in_TLAST;

   assign log_catted_TDATA = {in_TKEEP, in_TDATA};
   assign log_catted_TLAST = in_TLAST;

endmodule

// File: tb/tb_dbg_guv.sv
// Bench for dbg_guv: four chained cores (ADDR 0..3; core 2 non-sticky,
// core 3 with registered cmd_out) sharing one input stream.
module tb_dbg_guv;

   localparam int DW = 64, KW = 8, DEW = 16, IW = 16, NC = 4;
   localparam logic [2:0] PT = 3'b110, DR = 3'b100, LG = 3'b111, ST = 3'b001,
                          DL = 3'b101, PS = 3'b000, NR = 3'b010, LB = 3'b000;
   localparam logic [DW-1:0] CMD5 = 64'h50;

   typedef struct {
      logic          cv;
      logic [DW-1:0] cd;
      logic          iv, ordy, lrdy;
      logic [2:0]    e0, e1, e2;
      logic          f0, f3;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic          cmd_v;
   logic [DW-1:0] cmd_d;
   logic          in_v, in_last, o_rdy, l_rdy;
   logic [DW-1:0] in_d;
   logic [KW-1:0] in_k;
   logic [DEW-1:0] in_dest;
   logic [IW-1:0]  in_id;

   logic [NC:0]              cv;
   logic [NC:0][DW-1:0]      cd;
   logic [NC-1:0]            irdy, ovld, olast, lvld, llast;
   logic [NC-1:0][DW-1:0]    odata;
   logic [NC-1:0][KW-1:0]    okeep;
   logic [NC-1:0][DEW-1:0]   odest;
   logic [NC-1:0][IW-1:0]    oid;
   logic [NC-1:0][DW+KW-1:0] ldata;

   assign cv[0] = cmd_v;
   assign cd[0] = cmd_d;

   for (genvar k = 0; k < NC; k++) begin : g_core
      dbg_guv #(.ADDR(k), .STICKY_MODE(k == 2 ? 0 : 1), .PIPE_STAGE(k == 3 ? 1 : 0)) u_dut (
         .clk(clk), .rst(rst),
         .cmd_in_TDATA(cd[k]), .cmd_in_TVALID(cv[k]),
         .cmd_out_TDATA(cd[k+1]), .cmd_out_TVALID(cv[k+1]),
         .in_TDATA(in_d), .in_TVALID(in_v), .in_TKEEP(in_k), .in_TDEST(in_dest),
         .in_TID(in_id), .in_TLAST(in_last), .in_TREADY(irdy[k]),
         .out_TDATA(odata[k]), .out_TVALID(ovld[k]), .out_TKEEP(okeep[k]),
         .out_TDEST(odest[k]), .out_TID(oid[k]), .out_TLAST(olast[k]), .out_TREADY(o_rdy),
         .log_catted_TDATA(ldata[k]), .log_catted_TVALID(lvld[k]),
         .log_catted_TLAST(llast[k]), .log_catted_TREADY(l_rdy));
   end

   int   tests = 0, fails = 0;
   vec_t vecs[$];
   vec_t sb[$];

   function automatic vec_t mk(logic c, logic [DW-1:0] d, logic iv, logic ordy, logic lrdy,
                               logic [2:0] e0, logic [2:0] e1, logic [2:0] e2, logic f0, logic f3);
      vec_t v;
      v.cv = c; v.cd = d; v.iv = iv; v.ordy = ordy; v.lrdy = lrdy;
      v.e0 = e0; v.e1 = e1; v.e2 = e2; v.f0 = f0; v.f3 = f3;
      return v;
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(vec_t v);
      cmd_v   = v.cv;
      cmd_d   = v.cd;
      in_v    = v.iv;
      o_rdy   = v.ordy;
      l_rdy   = v.lrdy;
      in_d    = {$urandom, $urandom};
      in_k    = KW'($urandom);
      in_dest = DEW'($urandom);
      in_id   = IW'($urandom);
      in_last = 1'($urandom);
   endtask

   task automatic compare(int n, vec_t v);
      chk($sformatf("hs0[%0d]", n), {irdy[0], ovld[0], lvld[0]}, v.e0);
      chk($sformatf("hs1[%0d]", n), {irdy[1], ovld[1], lvld[1]}, v.e1);
      chk($sformatf("hs2[%0d]", n), {irdy[2], ovld[2], lvld[2]}, v.e2);
      chk($sformatf("fwd0[%0d]", n), cv[1], v.f0);
      chk($sformatf("fwd3[%0d]", n), cv[4], v.f3);
      if (v.f0) chk($sformatf("fwd0_data[%0d]", n), cd[1], v.cd);
      if (v.f3) chk($sformatf("fwd3_data[%0d]", n), cd[4], CMD5);
      chk($sformatf("out_data[%0d]", n), {odata[0], okeep[0], odest[0], oid[0], olast[0]},
          {in_d, in_k, in_dest, in_id, in_last});
      chk($sformatf("log_data[%0d]", n), {ldata[1], llast[1]}, {in_k, in_d, in_last});
   endtask

   task automatic step(int n, vec_t v);
      @(posedge clk);
      #1;
      apply(v);
      sb.push_back(v);
      @(negedge clk);
      compare(n, sb.pop_front());
   endtask

   initial begin
      // cmd, data, in_v, out_rdy, log_rdy, core0, core1, core2, fwd0, fwd3
      vecs.push_back(mk(0, 0,          1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(0, 0,          0, 1, 1, DR, DR, DR, 0, 0));
      vecs.push_back(mk(1, 64'h30000,  1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, 64'hF,      1, 1, 1, PT, PT, PT, 0, 0));
      repeat (3) vecs.push_back(mk(0, 0, 1, 1, 1, DR, PT, PT, 0, 0));
      vecs.push_back(mk(0, 0,          1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, 64'h0,      1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, 64'h50001,  1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, 64'hF,      1, 1, 1, PT, PT, PT, 0, 0));
      repeat (2) vecs.push_back(mk(0, 0, 1, 1, 1, LG, PT, PT, 0, 0));
      vecs.push_back(mk(0, 0,          1, 1, 0, ST, PT, PT, 0, 0));
      vecs.push_back(mk(0, 0,          0, 1, 0, LB, DR, DR, 0, 0));
      repeat (3) vecs.push_back(mk(0, 0, 1, 1, 1, LG, PT, PT, 0, 0));
      vecs.push_back(mk(0, 0,          1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, 64'h10000,  1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, 64'h10001,  1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, 64'hF,      1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(0, 0,          1, 0, 1, DL, NR, NR, 0, 0));
      vecs.push_back(mk(0, 0,          1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, 64'h10012,  1, 1, 1, PT, PT, PT, 1, 0));
      vecs.push_back(mk(1, 64'h1F,     1, 1, 1, PT, PT, PT, 1, 0));
      repeat (2) vecs.push_back(mk(0, 0, 1, 1, 1, PT, PS, PT, 0, 0));
      vecs.push_back(mk(1, 64'h00012,  1, 1, 1, PT, PS, PT, 1, 0));
      vecs.push_back(mk(1, 64'h1F,     1, 1, 1, PT, PS, PT, 1, 0));
      vecs.push_back(mk(0, 0,          1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, 64'h40022,  1, 1, 1, PT, PT, PT, 1, 0));
      vecs.push_back(mk(1, 64'h2F,     1, 1, 1, PT, PT, PT, 1, 0));
      repeat (2) vecs.push_back(mk(0, 0, 1, 1, 1, PT, PT, DR, 0, 0));
      vecs.push_back(mk(1, 64'h2F,     1, 1, 1, PT, PT, DR, 1, 0));
      vecs.push_back(mk(0, 0,          1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, CMD5,       1, 1, 1, PT, PT, PT, 1, 0));
      vecs.push_back(mk(0, 0,          1, 1, 1, PT, PT, PT, 0, 1));
      vecs.push_back(mk(0, 0,          1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(1, 64'hF,      1, 1, 1, PT, PT, PT, 0, 0));
      vecs.push_back(mk(0, 0,          1, 1, 1, DL, PT, PT, 0, 0));
      vecs.push_back(mk(0, 0,          1, 1, 1, PT, PT, PT, 0, 0));

      apply(mk(0, 0, 1, 1, 1, PT, PT, PT, 0, 0));
      step(-2, mk(0, 0, 1, 1, 1, PT, PT, PT, 0, 0));
      step(-1, mk(0, 0, 1, 1, 1, PT, PT, PT, 0, 0));
      rst = 1'b0;

      foreach (vecs[i]) step(i, vecs[i]);

      // Async reset while core 0 drops and core 3 holds a forwarded command.
      step(100, mk(1, 64'h40002, 1, 1, 1, PT, PT, PT, 0, 0));
      step(101, mk(1, 64'hF,     1, 1, 1, PT, PT, PT, 0, 0));
      step(102, mk(0, 0,         1, 1, 1, DL, PT, PT, 0, 0));
      step(103, mk(1, CMD5,      1, 1, 1, DR, PT, PT, 1, 0));
      @(posedge clk);
      #1 cmd_v = 1'b0;
      chk("pre_rst_fwd3", cv[4], 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_hs0", {irdy[0], ovld[0], lvld[0]}, PT);
      chk("async_rst_fwd3", cv[4], 1'b0);
      @(negedge clk) rst = 1'b0;
      step(104, mk(0, 0, 1, 1, 1, PT, PT, PT, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dbg_guv.md
DBG_GUV -- requirements
Module: dbg_guv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of stream data and command words.
REQ-002 SHALL have parameter DEST_WIDTH, default 16: TDEST width.
REQ-003 SHALL have parameter ID_WIDTH, default 16: TID width.
REQ-004 SHALL have parameter CNT_SIZE, default 16: width of the drop and log counters.
REQ-005 SHALL have parameter ADDR_WIDTH, default 12: width of the core-address field.
REQ-006 SHALL have parameter ADDR, default 0: this instance's address.
REQ-007 SHALL have parameter RESET_TYPE, default 0: accepted for compatibility only, with no effect.
REQ-008 SHALL have parameter STICKY_MODE, default 1: 1 keeps shadow registers after a latch, 0 clears them.
REQ-009 SHALL have parameter PIPE_STAGE, default 0: 1 registers cmd_out.
REQ-010 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock, reset asynchronous and active-high.
REQ-011 SHALL have ports cmd_in_TDATA (in, DATA_WIDTH) and cmd_in_TVALID (in, 1): command stream, no TREADY, never back-pressured.
REQ-012 SHALL have ports cmd_out_TDATA (out, DATA_WIDTH) and cmd_out_TVALID (out, 1): daisy-chain to the next core.
REQ-013 SHALL have in_TDATA (DATA_WIDTH), in_TVALID, in_TKEEP (DATA_WIDTH/8), in_TDEST (DEST_WIDTH), in_TID (ID_WIDTH), in_TLAST as inputs and in_TREADY as output.
REQ-014 SHALL have out_TDATA, out_TVALID, out_TKEEP, out_TDEST, out_TID, out_TLAST as outputs, with the same widths as in_*, and out_TREADY as input.
REQ-015 SHALL have log_catted_TDATA (out, DATA_WIDTH+DATA_WIDTH/8), log_catted_TVALID (out), log_catted_TLAST (out) and log_catted_TREADY (in).

Function
REQ-016 Command decode SHALL be: reg = TDATA[3:0], core address = TDATA[ADDR_WIDTH+3:4], payload = TDATA[DATA_WIDTH-1:ADDR_WIDTH+4].
REQ-017 A valid command whose address equals ADDR SHALL be consumed and SHALL NOT be forwarded; any other valid command SHALL be forwarded unchanged.
REQ-018 With PIPE_STAGE=0, forwarding SHALL be combinational; with PIPE_STAGE=1, it SHALL be registered with 1-cycle latency.
REQ-019 Shadow register writes SHALL be: reg 0 sets drop_cnt to payload[CNT_SIZE-1:0]; reg 1 sets log_cnt; reg 2 sets flags (bit0 keep_pausing, bit1 keep_logging, bit2 keep_dropping); other regs except 15 are ignored.
REQ-020 Reg 15 (latch) SHALL copy all shadow registers to the active registers on the next edge.
REQ-021 On a latch with STICKY_MODE=0, shadow registers SHALL be cleared to 0 in the same cycle.
REQ-022 The active registers SHALL define the mode: pause = keep_pausing; drop = keep_dropping or drop_cnt!=0; log = keep_logging or log_cnt!=0.
REQ-023 Pause SHALL have priority: in_TREADY=0, out_TVALID=0 and log_catted_TVALID=0.
REQ-024 in_TREADY SHALL equal !pause & (drop | out_TREADY) & (!log | log_catted_TREADY).
REQ-025 out_TVALID SHALL equal in_TVALID & !pause & !drop & (!log | log_catted_TREADY).
REQ-026 log_catted_TVALID SHALL equal in_TVALID & log & !pause & (drop | out_TREADY).
REQ-027 No combinational loop SHALL exist between these signals.
REQ-028 out_TDATA, out_TKEEP, out_TDEST, out_TID and out_TLAST SHALL equal in_* combinationally.
REQ-029 log_catted_TDATA SHALL equal {in_TKEEP, in_TDATA} and log_catted_TLAST SHALL equal in_TLAST; TDEST and TID are not logged.
REQ-030 A flit SHALL be in_TVALID & in_TREADY.
REQ-031 drop_cnt SHALL decrement by 1 per flit taken while drop is active and drop_cnt!=0, and SHALL saturate at 0.
REQ-032 log_cnt SHALL behave the same for logged flits.
REQ-033 Drop together with log SHALL log the flit and discard it from the output.
REQ-034 A latch SHALL win over a decrement in the same cycle.

Reset
REQ-035 rst SHALL asynchronously clear all shadow and active registers and the cmd_out pipeline register; cmd_out_TVALID SHALL be 0.
REQ-036 After reset the core SHALL be a transparent passthrough, with log_catted_TVALID=0.

Structure
REQ-037 Register indices (0, 1, 2, 15), flag bit positions and field offsets SHALL reside in shared package dbg_guv_pkg.
REQ-038 There SHALL be one sub-module, dbg_guv_cmd, for command decode, shadow/active registers and forwarding; the datapath is glue in dbg_guv.

Verification
REQ-039 Reset, in_TVALID=1, out_TREADY=1 -> out mirrors in every cycle; log_catted_TVALID=0; cmd_out_TVALID=0.
REQ-040 Core ADDR=0: write 0x30000 then latch 0xF -> exactly 3 flits dropped (out_TVALID=0, in_TREADY=1), then passthrough resumes.
REQ-041 Two chained cores (ADDR 0, 1): send 0x10012 then 0x1F -> core 0 forwards both; core 1 pauses (in2_TREADY=0); core 0 is unaffected.
REQ-042 Write 0x50001, latch, log_catted_TREADY=1 -> 5 flits appear on log with TDATA={TKEEP,TDATA}; hold log_catted_TREADY=0 -> in_TREADY=0.
REQ-043 STICKY_MODE=0: write 0x40002 and latch, then latch again -> second latch clears keep_dropping and passthrough resumes.
REQ-044 PIPE_STAGE=1: a command for address 5 -> cmd_out_TVALID asserts exactly one cycle later with identical TDATA.
